// File: rtl/core_idecode_stage_if.sv
// Fetch-to-decode and decode-to-EX handshake bundle.
// master is the fetch/EX side, slave is the decode stage.
interface core_idecode_stage_if;
   logic        IN_VALID;
   logic        IN_READY;
   logic [31:0] IN_INSTR;
   logic [31:0] IN_PC;
   logic        OUT_VALID;
   logic        OUT_READY;
   logic [31:0] OUT_PC;
   logic [31:0] OUT_IMM;
   logic [2:0]  OUT_FUNCT3;
   logic [6:0]  OUT_FUNCT7;
   logic [4:0]  OUT_RS1;
   logic [4:0]  OUT_RS2;
   logic [4:0]  OUT_RD;
   logic [13:0] OUT_CTRL;

   modport master (
      output IN_VALID, IN_INSTR, IN_PC, OUT_READY,
      input  IN_READY, OUT_VALID, OUT_PC, OUT_IMM,
      input  OUT_FUNCT3, OUT_FUNCT7, OUT_RS1, OUT_RS2,
      input  OUT_RD, OUT_CTRL
   );

   modport slave (
      input  IN_VALID, IN_INSTR, IN_PC, OUT_READY,
      output IN_READY, OUT_VALID, OUT_PC, OUT_IMM,
      output OUT_FUNCT3, OUT_FUNCT7, OUT_RS1, OUT_RS2,
      output OUT_RD, OUT_CTRL
   );
endinterface

// File: rtl/core_idecode_stage.sv
// RV32I(+M) decode stage: instruction queue, load-use stall,
// registered decoded bundle towards EX.
module core_idecode_stage #(
   parameter int QDEPTH   = 4,
   parameter bit ENABLE_M = 1'b0
) (
   input  logic                 CLK,
   input  logic                 NRST,
   input  logic                 FLUSH,
   input  logic                 EX_ISLOAD,
   input  logic [4:0]           EX_RD,
   core_idecode_stage_if.slave  bus
);
   localparam int AW = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;

   localparam int C_IMM  = 0;
   localparam int C_ALU  = 1;
   localparam int C_BR   = 2;
   localparam int C_LD   = 3;
   localparam int C_ST   = 4;
   localparam int C_AW   = 5;
   localparam int C_R1   = 6;
   localparam int C_R2   = 7;
   localparam int C_JAL  = 8;
   localparam int C_JALR = 9;
   localparam int C_LUI  = 10;
   localparam int C_AUI  = 11;
   localparam int C_MUL  = 12;
   localparam int C_ILL  = 13;

   typedef logic [AW-1:0] ptr_t;
   typedef logic [AW:0]   cnt_t;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] imm;
      logic [2:0]  funct3;
      logic [6:0]  funct7;
      logic [4:0]  rs1;
      logic [4:0]  rs2;
      logic [4:0]  rd;
      logic [13:0] ctrl;
   } id_ex_t;

   localparam cnt_t FULL = cnt_t'(QDEPTH);

   ptr_t        wptr_q, wptr_d;
   ptr_t        rptr_q, rptr_d;
   cnt_t        cnt_q, cnt_d;
   logic        out_valid_q, out_valid_d;
   id_ex_t      out_q, out_d;
   logic [31:0] pc_mem_q  [QDEPTH];
   logic [31:0] ins_mem_q [QDEPTH];

   logic        in_ready;
   logic        push;
   logic        pop;
   logic        hazard;
   logic [31:0] hd_ins;
   logic [31:0] hd_pc;
   logic [6:0]  op;
   logic [2:0]  f3;
   logic [6:0]  f7;
   logic [31:0] imm;
   logic [13:0] ctrl;
   logic        ill;
   id_ex_t      dec;

   assign hd_ins = ins_mem_q[rptr_q];
   assign hd_pc  = pc_mem_q[rptr_q];
   assign op     = hd_ins[6:0];
   assign f3     = hd_ins[14:12];
   assign f7     = hd_ins[31:25];

   always_comb begin
      ctrl = '0;
      imm  = '0;
      ill  = 1'b0;
      unique case (1'b1)
         (op == 7'h33): begin
            ctrl[C_ALU] = 1'b1;
            ctrl[C_AW]  = 1'b1;
            ctrl[C_R1]  = 1'b1;
            ctrl[C_R2]  = 1'b1;
            if (f7 == 7'h01) begin
               ill        = !ENABLE_M;
               ctrl[C_MUL] = ENABLE_M;
            end else if (f7 == 7'h20) begin
               ill = !((f3 == 3'd0) || (f3 == 3'd5));
            end else begin
               ill = (f7 != 7'h00);
            end
         end
         (op == 7'h13): begin
            ctrl[C_IMM] = 1'b1;
            ctrl[C_ALU] = 1'b1;
            ctrl[C_AW]  = 1'b1;
            ctrl[C_R1]  = 1'b1;
            imm = {{20{hd_ins[31]}}, hd_ins[31:20]};
            if (f3 == 3'd1) begin
               ill = (f7 != 7'h00);
            end else if (f3 == 3'd5) begin
               ill = (f7 != 7'h00) && (f7 != 7'h20);
            end
         end
         (op == 7'h03): begin
            ctrl[C_IMM] = 1'b1;
            ctrl[C_LD]  = 1'b1;
            ctrl[C_AW]  = 1'b1;
            ctrl[C_R1]  = 1'b1;
            imm = {{20{hd_ins[31]}}, hd_ins[31:20]};
         end
         (op == 7'h23): begin
            ctrl[C_IMM] = 1'b1;
            ctrl[C_ST]  = 1'b1;
            ctrl[C_R1]  = 1'b1;
            ctrl[C_R2]  = 1'b1;
            imm = {{20{hd_ins[31]}},
                   hd_ins[31:25], hd_ins[11:7]};
         end
         (op == 7'h63): begin
            ctrl[C_BR] = 1'b1;
            ctrl[C_R1] = 1'b1;
            ctrl[C_R2] = 1'b1;
            imm = {{19{hd_ins[31]}}, hd_ins[31],
                   hd_ins[7], hd_ins[30:25],
                   hd_ins[11:8], 1'b0};
         end
         (op == 7'h6F): begin
            ctrl[C_JAL] = 1'b1;
            ctrl[C_AW]  = 1'b1;
            imm = {{11{hd_ins[31]}}, hd_ins[31],
                   hd_ins[19:12], hd_ins[20],
                   hd_ins[30:21], 1'b0};
         end
         (op == 7'h67): begin
            ctrl[C_JALR] = 1'b1;
            ctrl[C_IMM]  = 1'b1;
            ctrl[C_AW]   = 1'b1;
            ctrl[C_R1]   = 1'b1;
            imm = {{20{hd_ins[31]}}, hd_ins[31:20]};
            ill = (f3 != 3'd0);
         end
         (op == 7'h37): begin
            ctrl[C_LUI] = 1'b1;
            ctrl[C_IMM] = 1'b1;
            ctrl[C_AW]  = 1'b1;
            imm = {hd_ins[31:12], 12'b0};
         end
         (op == 7'h17): begin
            ctrl[C_AUI] = 1'b1;
            ctrl[C_IMM] = 1'b1;
            ctrl[C_AW]  = 1'b1;
            imm = {hd_ins[31:12], 12'b0};
         end
         default: ill = 1'b1;
      endcase
      // Illegal bundles still flow to EX, but carry nothing to act on.
      if (ill) begin
         ctrl        = '0;
         ctrl[C_ILL] = 1'b1;
         imm         = '0;
      end
      if (hd_ins[11:7] == 5'd0) begin
         ctrl[C_AW] = 1'b0;
      end
   end

   always_comb begin
      dec.pc     = hd_pc;
      dec.imm    = imm;
      dec.funct3 = f3;
      dec.funct7 = f7;
      dec.rs1    = hd_ins[19:15];
      dec.rs2    = hd_ins[24:20];
      dec.rd     = hd_ins[11:7];
      dec.ctrl   = ctrl;
   end

   assign hazard = EX_ISLOAD && (EX_RD != 5'd0) &&
      ((ctrl[C_R1] && (hd_ins[19:15] == EX_RD)) ||
       (ctrl[C_R2] && (hd_ins[24:20] == EX_RD)));

   assign in_ready = (cnt_q != FULL);

   always_comb begin
      push = bus.IN_VALID && in_ready && !FLUSH;
      pop  = (cnt_q != '0) && !hazard && !FLUSH &&
             (!out_valid_q || bus.OUT_READY);
      wptr_d = push ? wptr_q + ptr_t'(1) : wptr_q;
      rptr_d = pop  ? rptr_q + ptr_t'(1) : rptr_q;
      case ({push, pop})
         2'b10:   cnt_d = cnt_q + cnt_t'(1);
         2'b01:   cnt_d = cnt_q - cnt_t'(1);
         default: cnt_d = cnt_q;
      endcase
      out_d       = pop ? dec : out_q;
      out_valid_d = out_valid_q;
      if (pop) begin
         out_valid_d = 1'b1;
      end else if (bus.OUT_READY) begin
         out_valid_d = 1'b0;
      end
      if (FLUSH) begin
         wptr_d      = '0;
         rptr_d      = '0;
         cnt_d       = '0;
         out_valid_d = 1'b0;
      end
   end

   always_ff @(posedge CLK or negedge NRST) begin
      if (!NRST) begin
         wptr_q      <= '0;
         rptr_q      <= '0;
         cnt_q       <= '0;
         out_valid_q <= 1'b0;
         out_q       <= '0;
      end else begin
         wptr_q      <= wptr_d;
         rptr_q      <= rptr_d;
         cnt_q       <= cnt_d;
         out_valid_q <= out_valid_d;
         out_q       <= out_d;
      end
   end

   // Storage is only read behind the count, so it needs no reset.
   always_ff @(posedge CLK) begin
      if (push) begin
         pc_mem_q[wptr_q]  <= bus.IN_PC;
         ins_mem_q[wptr_q] <= bus.IN_INSTR;
      end
   end

   assign bus.IN_READY   = in_ready;
   assign bus.OUT_VALID  = out_valid_q;
   assign bus.OUT_PC     = out_q.pc;
   assign bus.OUT_IMM    = out_q.imm;
   assign bus.OUT_FUNCT3 = out_q.funct3;
   assign bus.OUT_FUNCT7 = out_q.funct7;
   assign bus.OUT_RS1    = out_q.rs1;
   assign bus.OUT_RS2    = out_q.rs2;
   assign bus.OUT_RD     = out_q.rd;
   assign bus.OUT_CTRL   = out_q.ctrl;
endmodule
